// File: rtl/bc_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bc_sched_pkg : shared types for the BlockChecker stream scheduler   |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
package bc_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_SETTLE = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  localparam logic [7:0] ASCII_NUL = 8'h00;

  typedef logic req_id_t;

endpackage
`default_nettype wire

// File: rtl/bc_byte_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bc_byte_buf : DEPTH x 8 string buffer, sync write / comb read       |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module bc_byte_buf #(
  parameter int DEPTH = 32,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [IW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/bc_stream_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bc_stream_sched : buffers whole strings from two requesters and     |
// | replays each one gap-free into a freshly reset BlockChecker. rev 1.0|
// +--------------------------------------------------------------------+
module bc_stream_sched
  import bc_sched_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       bc_reset,
  output logic [7:0] bc_in,
  input  logic       bc_result,
  output logic       out_valid,
  output logic       out_id,
  output logic       out_result,
  output logic       out_err
);

  localparam int IW = $clog2(DEPTH);

  state_e        state_q;
  req_id_t       gnt_q;
  req_id_t       last_gnt_q;
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW-1:0] len_q;
  logic          err_q;
  logic          out_result_q;
  logic          out_err_q;

  logic          w_sel_valid;
  logic          w_sel_last;
  logic [7:0]    w_sel_data;
  logic          w_hs;
  logic          w_full;
  logic [7:0]    w_rd_data;

  assign w_sel_valid = gnt_q ? req1_valid : req0_valid;
  assign w_sel_last  = gnt_q ? req1_last  : req0_last;
  assign w_sel_data  = gnt_q ? req1_data  : req0_data;
  assign w_hs        = (state_q == ST_LOAD) && w_sel_valid;
  assign w_full      = (wptr_q == AW'(DEPTH));

  bc_byte_buf #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_buf (
    .clk   (clk),
    .we    (w_hs && !w_full),
    .waddr (wptr_q[IW-1:0]),
    .wdata (w_sel_data),
    .raddr (rptr_q[IW-1:0]),
    .rdata (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      gnt_q        <= 1'b0;
      last_gnt_q   <= 1'b1;
      wptr_q       <= '0;
      rptr_q       <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      out_result_q <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0_valid || req1_valid) begin
            gnt_q   <= (req0_valid && req1_valid) ? ~last_gnt_q : req1_valid;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_hs) begin
            // Bytes past DEPTH are swallowed so the requester can finish its string.
            if (w_full) begin
              err_q <= 1'b1;
            end else begin
              wptr_q <= wptr_q + AW'(1);
            end
            if (w_sel_last) begin
              if (w_full || err_q) begin
                out_result_q <= 1'b0;
                out_err_q    <= 1'b1;
                state_q      <= ST_REPORT;
              end else begin
                len_q     <= wptr_q + AW'(1);
                out_err_q <= 1'b0;
                state_q   <= ST_STREAM;
              end
            end
          end
        end
        ST_STREAM: begin
          rptr_q <= rptr_q + AW'(1);
          if (rptr_q + AW'(1) == len_q) begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          out_result_q <= bc_result;
          out_err_q    <= 1'b0;
          state_q      <= ST_REPORT;
        end
        ST_REPORT: begin
          wptr_q     <= '0;
          rptr_q     <= '0;
          err_q      <= 1'b0;
          last_gnt_q <= gnt_q;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready = (state_q == ST_LOAD) && (gnt_q == 1'b0);
  assign req1_ready = (state_q == ST_LOAD) && (gnt_q == 1'b1);
  assign bc_reset   = !((state_q == ST_STREAM) || (state_q == ST_SETTLE));
  assign bc_in      = (state_q == ST_STREAM) ? w_rd_data : ASCII_NUL;
  assign out_valid  = (state_q == ST_REPORT);
  assign out_id     = gnt_q;
  assign out_result = out_result_q;
  assign out_err    = out_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bc_stream_sched.sv
`default_nettype none
// Bench for bc_stream_sched: behavioural begin/end checker plus a verdict and
// stream scoreboard; a second DEPTH=4 instance covers the overflow path.
module tb_bc_stream_sched;

  typedef struct packed {
    logic id;
    logic res;
    logic err;
  } verdict_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_last, req1_valid, req1_last;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       bc_reset, bc_result, out_valid, out_id, out_result, out_err;
  logic [7:0] bc_in;

  logic       r4_valid, r4_last, r4_ready;
  logic [7:0] r4_data;
  logic       r4b_ready, bc4_reset, ov4, id4, res4, err4;
  logic [7:0] bc4_in;

  always #5 clk = ~clk;

  bc_stream_sched #(.DEPTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .bc_reset(bc_reset), .bc_in(bc_in), .bc_result(bc_result),
    .out_valid(out_valid), .out_id(out_id), .out_result(out_result), .out_err(out_err)
  );

  bc_stream_sched #(.DEPTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(r4_valid), .req0_data(r4_data), .req0_last(r4_last), .req0_ready(r4_ready),
    .req1_valid(1'b0), .req1_data(8'h00), .req1_last(1'b0), .req1_ready(r4b_ready),
    .bc_reset(bc4_reset), .bc_in(bc4_in), .bc_result(1'b1),
    .out_valid(ov4), .out_id(id4), .out_result(res4), .out_err(err4)
  );

  // Behavioural BlockChecker: result reflects all bytes seen, the open word included.
  int          m_depth;
  logic        m_err;
  logic [39:0] m_w;
  int          m_wl;
  int          nd;
  logic        ne;

  always_comb begin
    nd = m_depth;
    ne = m_err;
    if (m_wl == 5 && m_w == 40'h626567696e) begin
      nd = m_depth + 1;
    end else if (m_wl == 3 && m_w[23:0] == 24'h656e64) begin
      if (m_depth == 0) ne = 1'b1;
      else nd = m_depth - 1;
    end
    bc_result = !ne && (nd == 0);
  end

  always @(posedge clk) begin
    if (bc_reset) begin
      m_depth <= 0; m_err <= 1'b0; m_w <= '0; m_wl <= 0;
    end else if (bc_in >= 8'h61 && bc_in <= 8'h7a) begin
      if (m_wl < 5) begin
        m_w  <= {m_w[31:0], bc_in};
        m_wl <= m_wl + 1;
      end else begin
        m_wl <= 6;
      end
    end else begin
      m_depth <= nd; m_err <= ne; m_w <= '0; m_wl <= 0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  verdict_t   exp_q[$];
  string      str_q[$];
  logic [7:0] win[$];
  string      s_exp;
  int         cyc = 0, ov_cnt = 0, ov_cyc = 0, win_start = 0, exp_total = 0;
  int         d4_low = 0, hs4 = 0, d4_ov = 0;
  verdict_t   v_exp;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      win.delete();
    end else if (!bc_reset) begin
      if (win.size() == 0) win_start <= cyc;
      win.push_back(bc_in);
    end else if (win.size() > 0) begin
      if (str_q.size() == 0) begin
        check("unexpected stream", win.size(), 0);
      end else begin
        s_exp = str_q.pop_front();
        check("stream length", win.size(), s_exp.len() + 1);
        for (int i = 0; i < s_exp.len() && i < win.size(); i++)
          check("stream byte", win[i], s_exp[i]);
        check("settle byte", win[win.size()-1], 8'h00);
      end
      win.delete();
    end
    if (out_valid) begin
      ov_cnt <= ov_cnt + 1;
      ov_cyc <= cyc;
      if (exp_q.size() == 0) begin
        check("unexpected out_valid", 1, 0);
      end else begin
        v_exp = exp_q.pop_front();
        check("verdict {id,result,err}", {out_id, out_result, out_err}, v_exp);
      end
    end
    if (!bc4_reset) d4_low <= d4_low + 1;
    if (r4_valid && r4_ready) hs4 <= hs4 + 1;
    if (ov4) d4_ov <= d4_ov + 1;
  end

  task automatic drive(input int id, input logic v, input logic [7:0] d, input logic l);
    case (id)
      0: begin req0_valid = v; req0_data = d; req0_last = l; end
      1: begin req1_valid = v; req1_data = d; req1_last = l; end
      default: begin r4_valid = v; r4_data = d; r4_last = l; end
    endcase
  endtask

  function automatic logic is_ready(input int id);
    case (id)
      0: return req0_ready;
      1: return req1_ready;
      default: return r4_ready;
    endcase
  endfunction

  task automatic send_str(input int id, input string s, input bit gaps);
    int waits;
    bit acc;
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && i > 0 && $urandom_range(0, 1) == 1) begin
        drive(id, 1'b0, 8'h00, 1'b0);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      drive(id, 1'b1, s[i], (i == s.len() - 1));
      waits = 0;
      acc   = 0;
      while (!acc && waits < 200) begin
        @(negedge clk);
        acc = is_ready(id);
        waits++;
      end
      if (!acc) begin
        check({"handshake timeout ", s}, 0, 1);
        drive(id, 1'b0, 8'h00, 1'b0);
        return;
      end
      @(posedge clk);
      #1;
    end
    drive(id, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic expect_str(input logic id, input string s, input logic res, input logic err);
    exp_q.push_back('{id: id, res: res, err: err});
    if (!err) str_q.push_back(s);
    exp_total++;
  endtask

  task automatic wait_ov();
    int n = 0;
    while (ov_cnt < exp_total && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("verdict count", ov_cnt, exp_total);
  endtask

  task automatic wait_d4(input int target);
    int n = 0;
    while (d4_ov < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("dut4 verdict count", d4_ov, target);
  endtask

  int t0, base_low, base_hs, n;

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    drive(2, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst bc_reset", bc_reset, 1);
    check("rst bc_in", bc_in, 0);
    check("rst req0_ready", req0_ready, 0);
    check("rst req1_ready", req1_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_id", out_id, 0);
    check("rst out_result", out_result, 0);
    check("rst out_err", out_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Contention straight out of reset, then again: requester 0 wins both times.
    expect_str(1'b0, "begin end", 1'b1, 1'b0);
    expect_str(1'b1, "end begin", 1'b0, 1'b0);
    fork
      send_str(0, "begin end", 0);
      send_str(1, "end begin", 0);
    join
    wait_ov();
    @(posedge clk); #1;
    expect_str(1'b0, "begin begin end end", 1'b1, 1'b0);
    expect_str(1'b1, "begin", 1'b0, 1'b0);
    fork
      send_str(0, "begin begin end end", 0);
      send_str(1, "begin", 0);
    join
    wait_ov();

    // Latency of a back-to-back 9-byte string.
    @(posedge clk); #1;
    t0 = cyc;
    expect_str(1'b0, "begin end", 1'b1, 1'b0);
    send_str(0, "begin end", 0);
    wait_ov();
    check("out_valid latency", ov_cyc - t0, 20);
    check("stream start", win_start - t0, 10);

    @(posedge clk); #1;
    expect_str(1'b1, "end begin", 1'b0, 1'b0);
    send_str(1, "end begin", 0);
    wait_ov();

    @(posedge clk); #1;
    expect_str(1'b0, "begin end", 1'b1, 1'b0);
    send_str(0, "begin end", 1);
    wait_ov();

    @(posedge clk); #1;
    expect_str(1'b1, "x", 1'b1, 1'b0);
    send_str(1, "x", 0);
    wait_ov();

    // DEPTH=4 instance: exact fit, then overflow.
    base_low = d4_low; base_hs = hs4;
    send_str(2, "abcd", 0);
    wait_d4(1);
    @(negedge clk);
    check("d4 fit result", res4, 1);
    check("d4 fit err", err4, 0);
    check("d4 fit stream cycles", d4_low - base_low, 5);
    check("d4 fit handshakes", hs4 - base_hs, 4);
    @(posedge clk); #1;
    base_low = d4_low; base_hs = hs4;
    send_str(2, "begin", 0);
    wait_d4(2);
    @(negedge clk);
    check("d4 ovf result", res4, 0);
    check("d4 ovf err", err4, 1);
    check("d4 ovf id", id4, 0);
    check("d4 ovf stream cycles", d4_low - base_low, 0);
    check("d4 ovf handshakes", hs4 - base_hs, 5);

    // Reset in the middle of a replay.
    @(posedge clk); #1;
    send_str(0, "begin end", 0);
    n = 0;
    while (bc_reset && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reached stream", bc_reset, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid-reset bc_reset", bc_reset, 1);
    check("mid-reset out_valid", out_valid, 0);
    check("mid-reset bc_in", bc_in, 0);
    check("mid-reset req0_ready", req0_ready, 0);
    repeat (30) @(negedge clk);
    check("no verdict after reset", ov_cnt, exp_total);
    @(posedge clk); #1;
    expect_str(1'b0, "begin end", 1'b1, 1'b0);
    send_str(0, "begin end", 0);
    wait_ov();
    check("scoreboard drained", exp_q.size() + str_q.size(), 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
